// File: rtl/sum_display_scan_if.sv
// Pin bundle between the adder-result source and the 4-digit multiplexed display scanner.
interface sum_display_scan_if;
  logic [3:0] s_n;
  logic       cout_n;
  logic       load;
  logic [6:0] seg_n;
  logic [3:0] an_n;
  logic       dp_n;
  logic       busy;

  modport master (
    output s_n, cout_n, load,
    input  seg_n, an_n, dp_n, busy
  );

  modport slave (
    input  s_n, cout_n, load,
    output seg_n, an_n, dp_n, busy
  );
endinterface

// File: rtl/sum_display_scan.sv
// Captures a 5-bit adder result and scans it onto a 4-digit active-low 7-seg display; capture shows 2 clk after load, no backpressure.
// Decimal by default; defining SUM_DISPLAY_HEX_EN shows result[3:0] as hex on digit0 and result[4] on digit1.
module sum_display_scan #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input logic               clk,
  input logic               rst,
  sum_display_scan_if.slave bus
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [6:0] BLANK = 7'b1111111;

  if (REFRESH_DIV < 2 || REFRESH_DIV > (1 << 20)) begin : g_bad_div
    $error("REFRESH_DIV out of range 2..2^20");
  end

  logic [4:0]    r_result;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_sel;
  logic [3:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_busy;

  logic          w_wrap;
  logic [3:0]    w_lo;
  logic [3:0]    w_hi;
  logic          w_hi_blank;
  logic [3:0]    w_an_nxt;
  logic [6:0]    w_seg_nxt;

  function automatic logic [6:0] f_glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0010000;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;
      4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110;
      default: g = 7'b0001110;
    endcase
    return g;
  endfunction

  assign w_wrap = (r_cnt == CW'(REFRESH_DIV - 1));

`ifdef SUM_DISPLAY_HEX_EN
  always_comb begin
    w_lo       = r_result[3:0];
    w_hi       = {3'b000, r_result[4]};
    w_hi_blank = ~r_result[4];
  end
`else
  // Result never exceeds 31, so tens fits a 4-way compare instead of a divider.
  always_comb begin
    w_lo       = 4'd0;
    w_hi       = 4'd0;
    w_hi_blank = 1'b0;
    if (r_result >= 5'd30) begin
      w_hi = 4'd3;
      w_lo = 4'(r_result - 5'd30);
    end else if (r_result >= 5'd20) begin
      w_hi = 4'd2;
      w_lo = 4'(r_result - 5'd20);
    end else if (r_result >= 5'd10) begin
      w_hi = 4'd1;
      w_lo = 4'(r_result - 5'd10);
    end else begin
      w_hi       = 4'd0;
      w_lo       = r_result[3:0];
      w_hi_blank = 1'b1;
    end
  end
`endif

  // Anode and segments come from one select value so they always change together.
  always_comb begin
    w_an_nxt  = 4'b1110;
    w_seg_nxt = BLANK;
    case (r_sel)
      2'd0: begin
        w_an_nxt  = 4'b1110;
        w_seg_nxt = f_glyph(w_lo);
      end
      2'd1: begin
        w_an_nxt  = 4'b1101;
        w_seg_nxt = w_hi_blank ? BLANK : f_glyph(w_hi);
      end
      2'd2: begin
        w_an_nxt  = 4'b1011;
        w_seg_nxt = BLANK;
      end
      default: begin
        w_an_nxt  = 4'b0111;
        w_seg_nxt = BLANK;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result <= 5'd0;
      r_busy   <= 1'b0;
    end else begin
      if (bus.load) begin
        r_result <= {~bus.cout_n, ~bus.s_n};
      end
      r_busy <= bus.load;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_sel <= 2'd0;
    end else if (w_wrap) begin
      r_cnt <= '0;
      r_sel <= r_sel + 2'd1;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_an  <= 4'b1110;
      r_seg <= 7'b1000000;
    end else begin
      r_an  <= w_an_nxt;
      r_seg <= w_seg_nxt;
    end
  end

  assign bus.an_n  = r_an;
  assign bus.seg_n = r_seg;
  assign bus.busy  = r_busy;
  assign bus.dp_n  = 1'b1;

endmodule

// File: tb/tb_sum_display_scan.sv
// Directed vector table plus multi-cycle sequences and a per-cycle anode/segment scoreboard.
module tb_sum_display_scan;

  logic clk = 1'b0;
  logic rst = 1'b1;
  sum_display_scan_if bus ();

  sum_display_scan #(.REFRESH_DIV(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] s_n;
    logic       cout_n;
    logic [3:0] an;
    logic [6:0] seg;
    string      name;
  } vec_t;

  vec_t tbl[$];
  int   vecs = 0;
  int   miss = 0;
  bit   sb_en = 1'b0;
  int   m_cap = 0;
  int   m_shown = 0;
  logic m_busy = 1'b0;

  localparam logic [6:0] BL = 7'b1111111;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    vecs++;
    miss++;
    $display("FAIL %s: timed out waiting for anode at %0t", name, $time);
  endtask

  function automatic logic [6:0] glyph(input int v);
    case (v)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      10: return 7'b0001000;
      11: return 7'b0000011;
      12: return 7'b1000110;
      13: return 7'b0100001;
      14: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input int d, input int r);
`ifdef SUM_DISPLAY_HEX_EN
    if (d == 0) return glyph(r % 16);
    if (d == 1) return (r / 16 == 0) ? BL : glyph(r / 16);
`else
    if (d == 0) return glyph(r % 10);
    if (d == 1) return (r / 10 == 0) ? BL : glyph(r / 10);
`endif
    return BL;
  endfunction

  task automatic sb_check();
    int d;
    case (bus.an_n)
      4'b1110: d = 0;
      4'b1101: d = 1;
      4'b1011: d = 2;
      4'b0111: d = 3;
      default: d = -1;
    endcase
    chk("sb_an_onehot", 32'(d >= 0), 32'd1);
    if (d >= 0) chk("sb_seg_vs_anode", 32'(bus.seg_n), 32'(exp_seg(d, m_shown)));
    chk("sb_busy", 32'(bus.busy), 32'(m_busy));
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_cap   = 0;
      m_shown = 0;
      m_busy  = 1'b0;
    end else begin
      m_shown = m_cap;
      m_busy  = bus.load;
      if (bus.load) m_cap = 32'({~bus.cout_n, ~bus.s_n});
    end
    #1;
    if (sb_en && !rst) sb_check();
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_enter(input logic [3:0] target, input string name);
    int n = 0;
    while (bus.an_n == target && n < 24) begin step(); n++; end
    while (bus.an_n != target && n < 24) begin step(); n++; end
    if (n >= 24) timeout_fail(name);
  endtask

  task automatic wait_on(input logic [3:0] target, input string name);
    int n = 0;
    while (bus.an_n != target && n < 24) begin step(); n++; end
    if (n >= 24) timeout_fail(name);
  endtask

  task automatic load_val(input logic [3:0] s, input logic c);
    bus.s_n = s;
    bus.cout_n = c;
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    step();
  endtask

  // Called one sample after reset release: first change after 5 edges, then every 4.
  task automatic measure_scan();
    logic [3:0] seq [4];
    logic [3:0] prev;
    int n;
    seq[0] = 4'b1101; seq[1] = 4'b1011; seq[2] = 4'b0111; seq[3] = 4'b1110;
    for (int k = 0; k < 4; k++) begin
      prev = bus.an_n;
      n = 0;
      while (bus.an_n == prev && n < 12) begin step(); n++; end
      chk($sformatf("scan_interval_%0d", k), 32'(n), (k == 0) ? 32'd5 : 32'd4);
      chk($sformatf("scan_anode_%0d", k), 32'(bus.an_n), 32'(seq[k]));
    end
  endtask

  function automatic void add(input logic [3:0] s, input logic c, input logic [3:0] an,
                              input logic [6:0] seg, input string name);
    vec_t v;
    v.s_n = s; v.cout_n = c; v.an = an; v.seg = seg; v.name = name;
    tbl.push_back(v);
  endfunction

  initial begin
`ifdef SUM_DISPLAY_HEX_EN
    add(4'b1000, 1'b0, 4'b1110, 7'b1111000, "r23_d0");
    add(4'b1000, 1'b0, 4'b1101, 7'b1111001, "r23_d1");
    add(4'b1000, 1'b0, 4'b1011, BL,         "r23_d2");
    add(4'b1000, 1'b0, 4'b0111, BL,         "r23_d3");
    add(4'b1010, 1'b1, 4'b1110, 7'b0010010, "r5_d0");
    add(4'b1010, 1'b1, 4'b1101, BL,         "r5_d1");
    add(4'b0000, 1'b0, 4'b1110, 7'b0001110, "r31_d0");
    add(4'b0000, 1'b0, 4'b1101, 7'b1111001, "r31_d1");
    add(4'b1111, 1'b1, 4'b1110, 7'b1000000, "r0_d0");
    add(4'b1111, 1'b1, 4'b1101, BL,         "r0_d1");
    add(4'b0101, 1'b1, 4'b1110, 7'b0001000, "r10_d0");
    add(4'b0101, 1'b1, 4'b1101, BL,         "r10_d1");
    add(4'b1100, 1'b0, 4'b1110, 7'b0110000, "r19_d0");
    add(4'b1100, 1'b0, 4'b1101, 7'b1111001, "r19_d1");
    add(4'b0100, 1'b0, 4'b1110, 7'b0000011, "r27_d0");
    add(4'b0100, 1'b0, 4'b1101, 7'b1111001, "r27_d1");
`else
    add(4'b1000, 1'b0, 4'b1110, 7'b0110000, "r23_d0");
    add(4'b1000, 1'b0, 4'b1101, 7'b0100100, "r23_d1");
    add(4'b1000, 1'b0, 4'b1011, BL,         "r23_d2");
    add(4'b1000, 1'b0, 4'b0111, BL,         "r23_d3");
    add(4'b1010, 1'b1, 4'b1110, 7'b0010010, "r5_d0");
    add(4'b1010, 1'b1, 4'b1101, BL,         "r5_d1");
    add(4'b0000, 1'b0, 4'b1110, 7'b1111001, "r31_d0");
    add(4'b0000, 1'b0, 4'b1101, 7'b0110000, "r31_d1");
    add(4'b1111, 1'b1, 4'b1110, 7'b1000000, "r0_d0");
    add(4'b1111, 1'b1, 4'b1101, BL,         "r0_d1");
    add(4'b0101, 1'b1, 4'b1110, 7'b1000000, "r10_d0");
    add(4'b0101, 1'b1, 4'b1101, 7'b1111001, "r10_d1");
    add(4'b1100, 1'b0, 4'b1110, 7'b0010000, "r19_d0");
    add(4'b1100, 1'b0, 4'b1101, 7'b1111001, "r19_d1");
    add(4'b0100, 1'b0, 4'b1110, 7'b1111000, "r27_d0");
    add(4'b0100, 1'b0, 4'b1101, 7'b0100100, "r27_d1");
`endif

    bus.s_n = 4'b1111;
    bus.cout_n = 1'b1;
    bus.load = 1'b0;
    step();
    step();
    chk("rst_an", 32'(bus.an_n), 32'b1110);
    chk("rst_seg", 32'(bus.seg_n), 32'b1000000);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_dp", 32'(bus.dp_n), 32'd1);
    rst = 1'b0;
    sb_en = 1'b1;
    measure_scan();

    for (int i = 0; i < tbl.size(); i++) begin
      load_val(tbl[i].s_n, tbl[i].cout_n);
      wait_on(tbl[i].an, tbl[i].name);
      chk(tbl[i].name, 32'(bus.seg_n), 32'(tbl[i].seg));
    end

    // Two-clock capture latency while digit0 stays selected.
    load_val(4'b1111, 1'b1);
    wait_enter(4'b1110, "lat_enter");
    bus.s_n = 4'b1000;
    bus.cout_n = 1'b0;
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    chk("lat_busy_hi", 32'(bus.busy), 32'd1);
    chk("lat_seg_old", 32'(bus.seg_n), 32'b1000000);
    step();
    chk("lat_busy_lo", 32'(bus.busy), 32'd0);
    chk("lat_seg_new", 32'(bus.seg_n), 32'(exp_seg(0, 23)));

    // Back-to-back loads keep busy high until the last one lands.
    bus.load = 1'b1;
    step();
    chk("b2b_busy1", 32'(bus.busy), 32'd1);
    step();
    bus.load = 1'b0;
    chk("b2b_busy2", 32'(bus.busy), 32'd1);
    step();
    chk("b2b_busy3", 32'(bus.busy), 32'd0);

    // Hold: inputs toggle with load low; scoreboard keeps comparing against 23.
    for (int i = 0; i < 40; i++) begin
      bus.s_n = 4'($urandom);
      bus.cout_n = 1'($urandom);
      step();
      chk("hold_busy", 32'(bus.busy), 32'd0);
    end
    wait_enter(4'b1101, "hold_enter");
    chk("hold_d1", 32'(bus.seg_n), 32'(exp_seg(1, 23)));

    // Load on the wrap edge: the newly selected digit carries the new value.
    wait_enter(4'b0111, "wrap_enter");
    bus.s_n = 4'b0000;
    bus.cout_n = 1'b0;
    step();
    step();
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    chk("wrap_an_hold", 32'(bus.an_n), 32'b0111);
    chk("wrap_busy", 32'(bus.busy), 32'd1);
    step();
    chk("wrap_an_next", 32'(bus.an_n), 32'b1110);
`ifdef SUM_DISPLAY_HEX_EN
    chk("wrap_seg_new", 32'(bus.seg_n), 32'b0001110);
`else
    chk("wrap_seg_new", 32'(bus.seg_n), 32'b1111001);
`endif

    // Reset mid-capture: outputs clear asynchronously and the capture is lost.
    wait_enter(4'b1011, "mid_enter");
    bus.s_n = 4'b1000;
    bus.cout_n = 1'b0;
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_an", 32'(bus.an_n), 32'b1110);
    chk("async_seg", 32'(bus.seg_n), 32'b1000000);
    chk("async_busy", 32'(bus.busy), 32'd0);
    step();
    step();
    rst = 1'b0;
    measure_scan();
    wait_enter(4'b1110, "post_rst_enter");
    chk("post_rst_d0", 32'(bus.seg_n), 32'b1000000);
    wait_enter(4'b1101, "post_rst_d1_enter");
    chk("post_rst_d1", 32'(bus.seg_n), 32'(BL));

    sb_en = 1'b0;
    step();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule

// File: doc/sum_display_scan.md
SUM_DISPLAY_SCAN -- requirements
Module: sum_display_scan

Interface
REQ-001 The module SHALL have parameter REFRESH_DIV, default 100000, giving clk cycles per digit slot; legal range 2..2^20.
REQ-002 clk  input  1  Single clock; all state SHALL be clocked on its rising edge.
REQ-003 rst  input  1  Reset, asynchronous and active-high.
REQ-004 s_n  input  4  Adder sum, active-low (true sum = ~s_n).
REQ-005 cout_n  input  1  Adder carry-out, active-low (true carry = ~cout_n).
REQ-006 load  input  1  Capture strobe, synchronous to clk, active-high.
REQ-007 seg_n  output  7  Segments {g,f,e,d,c,b,a}, active-low, registered.
REQ-008 an_n  output  4  Digit anodes, active-low one-hot, registered; an_n[0] is the rightmost digit.
REQ-009 dp_n  output  1  Decimal point, active-low; constant 1.
REQ-010 busy  output  1  High in the cycle after a capture while the new value is not yet on any digit.

Function
REQ-011 On a rising clk edge with load=1, the block SHALL capture result = {~cout_n, ~s_n} (5 bits, 0..31) into a held register; load held high SHALL recapture every cycle.
REQ-012 With load=0, the held result SHALL remain unchanged indefinitely.
REQ-013 In decimal mode, digit0 SHALL show result mod 10, and digit1 SHALL show result/10 (0..3).
REQ-014 digit1 SHALL be blanked (seg_n=7'b1111111) when the tens value is 0; digit0 SHALL never be blanked.
REQ-015 Digits 2 and 3 SHALL always be blank but still scanned.
REQ-016 Glyphs SHALL use the standard active-low encoding, e.g. 0=1000000, 1=1111001, 3=0110000, 5=0010010, 9=0010000.
REQ-017 A refresh counter SHALL count 0..REFRESH_DIV-1 and wrap. On wrap, digit select SHALL advance 0->1->2->3->0.
REQ-018 an_n and seg_n SHALL update together one clk after digit select or held result changes; no cycle SHALL show one digit's anode with another digit's segments.
REQ-019 A capture SHALL be reflected on the currently selected digit's outputs exactly 2 clk after the load edge; the scan position SHALL NOT reset on load.
REQ-020 busy SHALL assert for exactly the 1 clk between capture and output update; a load during busy SHALL restart it.
REQ-021 If load coincides with a counter wrap, the capture SHALL take effect, and the new digit SHALL show the new value.

Reset
REQ-022 While rst=1: held result=0, refresh counter=0, digit select=0, an_n=4'b1110, seg_n=7'b1000000 ("0"), busy=0, dp_n=1.
REQ-023 Reset asserted mid-scan or mid-capture SHALL discard the pending capture. After release, scanning SHALL restart at digit 0 with a full REFRESH_DIV slot.

Configuration
REQ-024 Macro SUM_DISPLAY_HEX_EN: when defined, digit0 SHALL show result[3:0] as hex 0-F (A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110), and digit1 SHALL show result[4] (blank when 0). When undefined, decimal behaviour of REQ-013/014 applies. Timing and all other behaviour SHALL be identical in both builds.

Verification (bench uses REFRESH_DIV=4)
REQ-025 Reset: assert rst mid-slot -> an_n=1110 and seg_n=1000000 immediately. After release, an_n steps 1101, 1011, 0111, 1110 every 4 clk.
REQ-026 Decimal capture: s_n=4'b1000, cout_n=0 (result 23), pulse load while digit0 selected -> 2 clk later seg_n=0110000 ("3"). When digit1 is selected, seg_n=0100100 ("2").
REQ-027 Blanking: s_n=4'b1010, cout_n=1 (result 5), load -> digit0 "5", digit1/2/3 seg_n=1111111. Max: s_n=0000, cout_n=0 (result 31) -> digit1 "3", digit0 "1".
REQ-028 Hold: capture 23, then change s_n/cout_n every clk with load=0 for 40 clk -> displayed digits unchanged. Check busy=1 for exactly one clk after each load.
REQ-029 Edge coincidence: pulse load on the cycle the refresh counter wraps -> the newly selected digit shows the new value. No anode/segment mismatch in any cycle (scoreboard check).
REQ-030 With SUM_DISPLAY_HEX_EN defined: result 27 -> digit0 "b" (0000011), digit1 "1". Result 10 -> digit0 "A", digit1 blank.
